// File: rtl/bit_serial_adder.sv
// Multi-cycle adder/subtractor: one BITS_PER_CYCLE-wide adder slice plus a carry
// flop processes the operands LSB-first over WIDTH/BITS_PER_CYCLE cycles.
module bit_serial_adder #(
   parameter int unsigned WIDTH          = 16,
   parameter int unsigned BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             sub,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned BPC = BITS_PER_CYCLE;
   localparam int unsigned N   = WIDTH / BPC;
   localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned SW  = BPC + 1;

   generate
      if (WIDTH < 1 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_param_check
         $error("bit_serial_adder: BITS_PER_CYCLE must divide WIDTH exactly");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic             accept;
   logic             last;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [SW-1:0]    sum;
   logic             msb_cin;

   // Next-state decode; accept covers both IDLE and back-to-back DONE starts
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      last       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (cnt == CW'(N - 1)) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Chunk adder; the carry into the MSB is recovered as a^b^sum of that bit
   always_comb begin
      sum      = SW'(a_sr[BPC-1:0]) + SW'(b_sr[BPC-1:0]) + SW'(carry);
      acc_next = WIDTH'({sum[BPC-1:0], acc} >> BPC);
      msb_cin  = a_sr[BPC-1] ^ b_sr[BPC-1] ^ sum[BPC-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ready <= 1'b1;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         ready <= (state_next != RUN);
         done  <= (state_next == DONE);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sr      <= '0;
         b_sr      <= '0;
         acc       <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         out       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else if (accept) begin
         a_sr  <= a;
         b_sr  <= b ^ {WIDTH{sub}};
         carry <= carry_in ^ sub;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_sr  <= a_sr >> BPC;
         b_sr  <= b_sr >> BPC;
         acc   <= acc_next;
         carry <= sum[BPC];
         cnt   <= cnt + CW'(1);
         if (last) begin
            out       <= acc_next;
            carry_out <= sum[BPC];
            overflow  <= msb_cin ^ sum[BPC];
         end
      end
   end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed cases, reset abort,
// back-to-back operation, an 8/4 instance and exhaustive 4-bit cross-checks.
module tb_bit_serial_adder;

   logic        clk = 1'b0;
   logic        reset;
   logic        carry_in;
   logic        sub;
   logic [15:0] a;
   logic [15:0] b;
   logic [3:0]  start_v;
   logic [3:0]  ready_v;
   logic [3:0]  done_v;
   logic [3:0]  cout_v;
   logic [3:0]  ovf_v;
   logic [15:0] out16;
   logic [7:0]  out8;
   logic [3:0]  out4a;
   logic [3:0]  out4b;
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   bit_serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut16 (
      .clk(clk), .reset(reset), .start(start_v[0]), .a(a), .b(b),
      .carry_in(carry_in), .sub(sub), .ready(ready_v[0]), .done(done_v[0]),
      .out(out16), .carry_out(cout_v[0]), .overflow(ovf_v[0]));

   bit_serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut8 (
      .clk(clk), .reset(reset), .start(start_v[1]), .a(a[7:0]), .b(b[7:0]),
      .carry_in(carry_in), .sub(sub), .ready(ready_v[1]), .done(done_v[1]),
      .out(out8), .carry_out(cout_v[1]), .overflow(ovf_v[1]));

   bit_serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(1)) dut4a (
      .clk(clk), .reset(reset), .start(start_v[2]), .a(a[3:0]), .b(b[3:0]),
      .carry_in(carry_in), .sub(sub), .ready(ready_v[2]), .done(done_v[2]),
      .out(out4a), .carry_out(cout_v[2]), .overflow(ovf_v[2]));

   bit_serial_adder #(.WIDTH(4), .BITS_PER_CYCLE(2)) dut4b (
      .clk(clk), .reset(reset), .start(start_v[3]), .a(a[3:0]), .b(b[3:0]),
      .carry_in(carry_in), .sub(sub), .ready(ready_v[3]), .done(done_v[3]),
      .out(out4b), .carry_out(cout_v[3]), .overflow(ovf_v[3]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int width_of(input int which);
      case (which)
         0:       return 16;
         1:       return 8;
         default: return 4;
      endcase
   endfunction

   function automatic int lat_of(input int which);
      case (which)
         0:       return 16;
         1:       return 2;
         2:       return 4;
         default: return 2;
      endcase
   endfunction

   function automatic logic [15:0] out_of(input int which);
      case (which)
         0:       return out16;
         1:       return 16'(out8);
         2:       return 16'(out4a);
         default: return 16'(out4b);
      endcase
   endfunction

   // Reference: integer add/subtract, then unsigned carry and signed range test
   function automatic logic [17:0] model(input int w, input int aa, input int bb,
                                         input int ci, input int s);
      int full;
      int sa;
      int sb;
      int sr;
      logic co;
      logic ov;
      full = s ? (aa - bb - ci) : (aa + bb + ci);
      co   = s ? (full >= 0) : (full >= (1 << w));
      sa   = (aa >= (1 << (w - 1))) ? aa - (1 << w) : aa;
      sb   = (bb >= (1 << (w - 1))) ? bb - (1 << w) : bb;
      sr   = s ? (sa - sb - ci) : (sa + sb + ci);
      ov   = (sr >= (1 << (w - 1))) || (sr < -(1 << (w - 1)));
      return {ov, co, 16'(full & ((1 << w) - 1))};
   endfunction

   task automatic check_result(input string tag, input int which, input logic [15:0] aa,
                               input logic [15:0] bb, input logic ci, input logic s);
      int mask;
      logic [17:0] exp;
      mask = (1 << width_of(which)) - 1;
      exp  = model(width_of(which), int'(aa) & mask, int'(bb) & mask, int'(ci), int'(s));
      check({tag, "_out"},  32'(out_of(which)),   32'(exp[15:0]));
      check({tag, "_cout"}, 32'(cout_v[which]),   32'(exp[16]));
      check({tag, "_ovf"},  32'(ovf_v[which]),    32'(exp[17]));
   endtask

   task automatic run_op(input string tag, input int which, input logic [15:0] aa,
                         input logic [15:0] bb, input logic ci, input logic s);
      int edges;
      @(negedge clk);
      check({tag, "_ready"}, 32'(ready_v[which]), 32'd1);
      a = aa; b = bb; carry_in = ci; sub = s;
      start_v[which] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[which] = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      carry_in = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      edges = 0;
      while (!done_v[which] && edges < 40) begin
         @(negedge clk);
         edges++;
      end
      check({tag, "_latency"}, 32'(edges), 32'(lat_of(which)));
      check_result(tag, which, aa, bb, ci, s);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done_v[which]), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      int pulses;
      reset = 1'b1; start_v = '0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_ready", 32'(ready_v), 32'hF);
      check("rst_done",  32'(done_v),  32'h0);
      check("rst_out",   32'(out16),   32'h0);
      check("rst_cout",  32'(cout_v),  32'h0);
      check("rst_ovf",   32'(ovf_v),   32'h0);

      run_op("wrap",     0, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
      check("wrap_lit",  32'({ovf_v[0], cout_v[0], out16}), 32'h1_0000);
      run_op("ovf_add",  0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
      check("ovf_add_lit", 32'({ovf_v[0], cout_v[0], out16}), 32'h2_8000);
      run_op("ovf_sub",  0, 16'h8000, 16'h0001, 1'b0, 1'b1);
      check("ovf_sub_lit", 32'({ovf_v[0], cout_v[0], out16}), 32'h3_7FFF);

      // start held high: operands changed mid-RUN, second op taken in DONE
      @(negedge clk);
      a = 16'h00FF; b = 16'h0F0F; carry_in = 1'b0; sub = 1'b0; start_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a = 16'h1234; b = 16'h0101;
      k = 0;
      while (!done_v[0] && k < 40) begin @(negedge clk); k++; end
      check("b2b_lat", 32'(k), 32'd16);
      check_result("b2b_first", 0, 16'h00FF, 16'h0F0F, 1'b0, 1'b0);
      @(negedge clk);
      k = 1;
      while (!done_v[0] && k < 40) begin @(negedge clk); k++; end
      start_v[0] = 1'b0;
      check("b2b_gap", 32'(k), 32'd17);
      check_result("b2b_second", 0, 16'h1234, 16'h0101, 1'b0, 1'b0);

      // reset aborts a running operation
      @(negedge clk);
      a = 16'h1234; b = 16'h1111; start_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_ready", 32'(ready_v[0]), 32'd1);
      check("abort_done",  32'(done_v[0]),  32'd0);
      check("abort_out",   32'(out16),      32'd0);
      pulses = 0;
      repeat (25) begin
         @(negedge clk);
         if (done_v[0]) pulses++;
      end
      check("abort_no_done", 32'(pulses), 32'd0);
      run_op("post_abort", 0, 16'h0003, 16'h0004, 1'b0, 1'b0);
      check("post_abort_lit", 32'(out16), 32'h0007);

      run_op("w8", 1, 16'h00FF, 16'h0001, 1'b1, 1'b0);
      check("w8_lit", 32'({ovf_v[1], cout_v[1], out8}), 32'h1_01);

      for (int w = 2; w <= 3; w++)
         for (int s = 0; s < 2; s++)
            for (int ci = 0; ci < 2; ci++)
               for (int x = 0; x < 16; x++)
                  for (int y = 0; y < 16; y++)
                     run_op(w == 2 ? "x4b1" : "x4b2", w, 16'(x), 16'(y), 1'(ci), 1'(s));

      repeat (30)
         run_op("rand16", 0, 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Multi-cycle, parametrised adder/subtractor for the Hack datapath. It reuses one BITS_PER_CYCLE-wide full-adder slice and a carry flip-flop to add two WIDTH-bit operands over WIDTH/BITS_PER_CYCLE cycles, trading latency for area. A start/ready/done handshake lets a controller or ALU sequencer issue operations. The block also reports a carry-out flag and a signed-overflow flag.

## Interface
- WIDTH, 16, operand and result width in bits; must be ≥ 1.
- BITS_PER_CYCLE, 1, bits processed per cycle; must divide WIDTH exactly, otherwise elaboration fails via a generate-time check.
- N (local), WIDTH/BITS_PER_CYCLE, number of compute cycles.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request an operation; sampled only while ready=1.
- a  in  WIDTH  operand A; latched on the accepting edge.
- b  in  WIDTH  operand B; latched on the accepting edge.
- carry_in  in  1  initial carry in add mode, or borrow-in in subtract mode; latched on the accepting edge.
- sub  in  1  mode: 0 computes a+b+carry_in, 1 computes a−b−carry_in; latched on the accepting edge.
- ready  out  1  high when a start will be accepted (IDLE or DONE).
- done  out  1  one-cycle pulse: result valid.
- out  out  WIDTH  result register.
- carry_out  out  1  carry out of the MSB (in subtract mode, 1 means no borrow).
- overflow  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- **State machine:** IDLE, RUN, DONE.
- **IDLE:** ready=1, done=0. On start=1:
  - latch a into a shift register, and latch b XOR {WIDTH{sub}} into a shift register;
  - set the carry flop to carry_in XOR sub;
  - clear the chunk counter;
  - go to RUN.
- **RUN:** ready=0. Each cycle:
  - add the low BITS_PER_CYCLE bits of both shift registers plus the carry flop;
  - shift the sum chunk into the accumulator from the MSB side;
  - shift both operand registers right by BITS_PER_CYCLE;
  - update the carry flop and increment the counter.
- **RUN exit:** on the cycle processing chunk N−1, load out from the completed sum, and load carry_out and overflow. Overflow uses the carry into bit WIDTH−1, which is captured inside the last chunk's ripple. Then go to DONE.
- **DONE:** done=1, ready=1 for exactly one cycle.
  - start=1 in this cycle is accepted exactly as in IDLE (back-to-back operation), going to RUN.
  - Otherwise go to IDLE.
- **Ignored input:** start while in RUN is ignored; no queuing.
- **Result hold:** out, carry_out and overflow change only at completion. They hold the previous result during RUN and until the next completion.
- **Arithmetic:** all arithmetic is modulo 2^WIDTH. For WIDTH=1, overflow equals carry_in-to-MSB XOR carry_out, the same rule as any other width.

## Timing
- **Reset values:** state=IDLE, ready=1, done=0, out=0, carry_out=0, overflow=0. Carry flop, counter and shift registers are cleared.
- **Reset priority:** reset overrides everything, including start in the same cycle. Reset during RUN aborts the operation with no done pulse, and the outputs go to their reset values at that edge.
- **Latency:** with the accepting edge as edge 0, chunk k is registered at edge k+1. out/flags are updated and done=1 follow edge N. done is visible N cycles after acceptance (16 cycles for the default parameters, 2 for WIDTH=8, BITS_PER_CYCLE=4).
- **Throughput:** with start held high, a new operation is accepted on every DONE cycle, giving one result per N+1 cycles.
- **Combinational paths:** ready and done are decoded from state only. There is no combinational path from any input to any output.

## Test plan
- **Wrap with carry:** defaults, a=0x0001, b=0xFFFF, carry_in=0, sub=0, start pulse → done exactly 16 cycles after acceptance; out=0x0000, carry_out=1, overflow=0.
- **Signed overflow, add:** a=0x7FFF, b=0x0001, add → out=0x8000, carry_out=0, overflow=1. Then sub=1, a=0x8000, b=0x0001, carry_in=0 → out=0x7FFF, carry_out=1, overflow=1.
- **Start ignored in RUN; back-to-back:** hold start=1 throughout with operands changed mid-RUN → the first result uses only the operands latched at acceptance. A second operation is accepted in the DONE cycle; done pulses occur 17 cycles apart.
- **Reset mid-operation:** assert reset at RUN cycle 5 → next cycle ready=1, done=0, out=0; no done pulse follows. A fresh 0x0003+0x0004 then yields 0x0007.
- **Parametrised instance:** WIDTH=8, BITS_PER_CYCLE=4, a=0xFF, b=0x01, carry_in=1 → done 2 cycles after acceptance; out=0x01, carry_out=1, overflow=0.
- **Exhaustive cross-check:** WIDTH=4, BITS_PER_CYCLE=1 and 2, all a, b, carry_in, sub combinations → out, carry_out and overflow match a reference model for every case.
